// File: rtl/router_switch_alloc.sv
// router_switch_alloc
// Three-port tree-router switch allocator. Ports are parent (0), child1 (1)
// and child2 (2). Each incoming packet is routed down to a child or up to the
// parent from its 3-bit destination field. Each output owns a one-entry
// register and a round-robin arbiter. A parent packet that would be routed
// back up is misrouted: it is accepted, discarded and flagged on drop_err.
//
// Handshake (all ports): a transfer happens on a rising clk edge where valid
// and ready are both 1. Upstream holds valid/data stable until it sees ready,
// and never waits for ready before raising valid. in_ready is combinational
// from the current inputs and register state. out_valid/out_data are
// registered and stay put while the downstream holds out_ready low.

module router_switch_alloc #(
    parameter int         WIDTH_packet = 14,
    parameter logic [2:0] ROUTER_ID    = 3'b000,
    parameter logic [2:0] ROUTER_MASK  = 3'b110,
    parameter int         CHILD_BIT    = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2:0]                in_valid,
    input  logic [3*WIDTH_packet-1:0] in_data,
    output logic [2:0]                in_ready,
    output logic [2:0]                out_valid,
    output logic [3*WIDTH_packet-1:0] out_data,
    input  logic [2:0]                out_ready,
    output logic                      drop_err
);

    // Output-slot state; slot_state is the per-output FSM state and is the
    // signal to probe when observing slot occupancy.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    localparam logic [1:0] PORT_PARENT = 2'd0;
    localparam logic [1:0] PORT_CHILD1 = 2'd1;
    localparam logic [1:0] PORT_CHILD2 = 2'd2;

    slot_state_e             slot_state   [3];
    slot_state_e             slot_state_d [3];
    logic [WIDTH_packet-1:0] slot_data    [3];
    logic [WIDTH_packet-1:0] slot_data_d  [3];
    logic [1:0]              rr_ptr       [3];
    logic [1:0]              rr_ptr_d     [3];
    logic                    drop_q;
    logic                    drop_d;

    logic [2:0]              in_dest      [3];
    logic [1:0]              in_tgt       [3];
    logic                    parent_misroute;
    logic [2:0]              req          [3];   // req[o][i]: input i wants output o
    logic [2:0]              gnt          [3];   // gnt[o][i]: output o grants input i
    logic [2:0]              out_free;

    // Round-robin pick: first requester in the order p, p+1, p+2 (mod 3).
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [2:0] g;
        g = 3'b000;
        case (p)
            2'd1: begin
                if (r[1])      g = 3'b010;
                else if (r[2]) g = 3'b100;
                else if (r[0]) g = 3'b001;
            end
            2'd2: begin
                if (r[2])      g = 3'b100;
                else if (r[0]) g = 3'b001;
                else if (r[1]) g = 3'b010;
            end
            default: begin
                if (r[0])      g = 3'b001;
                else if (r[1]) g = 3'b010;
                else if (r[2]) g = 3'b100;
            end
        endcase
        return g;
    endfunction

    // Pointer after a grant: the input just served drops to lowest priority.
    function automatic logic [1:0] ptr_after(input logic [2:0] g);
        logic [1:0] n;
        case (g)
            3'b001:  n = 2'd1;
            3'b010:  n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // Per-input destination decode and route target.
    for (genvar gi = 0; gi < 3; gi++) begin : g_route
        assign in_dest[gi] = in_data[gi*WIDTH_packet +: 3];
        assign in_tgt[gi]  = ((in_dest[gi] & ROUTER_MASK) == (ROUTER_ID & ROUTER_MASK))
                             ? (in_dest[gi][CHILD_BIT] ? PORT_CHILD2 : PORT_CHILD1)
                             : PORT_PARENT;
    end

    // A parent packet heading back up has nowhere legal to go.
    assign parent_misroute = in_valid[0] && (in_tgt[0] == PORT_PARENT);

    // Build the request matrix; a misrouted parent packet never requests.
    always_comb begin
        for (int o = 0; o < 3; o++) begin
            req[o] = 3'b000;
            for (int i = 0; i < 3; i++) begin
                req[o][i] = in_valid[i] && (in_tgt[i] == 2'(o)) && !(i == 0 && o == 0);
            end
        end
    end

    // Per-output arbitration; an output is free when empty or draining now.
    always_comb begin
        for (int o = 0; o < 3; o++) begin
            out_free[o] = (slot_state[o] == SLOT_EMPTY) || out_ready[o];
            gnt[o]      = out_free[o] ? rr_pick(req[o], rr_ptr[o]) : 3'b000;
        end
    end

    // Accept every granted input plus any misrouted parent packet; nothing
    // is accepted while reset is asserted.
    always_comb begin
        in_ready = 3'b000;
        if (rst_n) begin
            for (int o = 0; o < 3; o++) begin
                in_ready = in_ready | gnt[o];
            end
            in_ready[0] = in_ready[0] | parent_misroute;
        end
    end

    // Next-state for each output slot, its data and its arbiter pointer.
    always_comb begin
        for (int o = 0; o < 3; o++) begin
            slot_state_d[o] = slot_state[o];
            slot_data_d[o]  = slot_data[o];
            rr_ptr_d[o]     = rr_ptr[o];
            if (|gnt[o]) begin
                slot_state_d[o] = SLOT_FULL;
                rr_ptr_d[o]     = ptr_after(gnt[o]);
                case (gnt[o])
                    3'b010:  slot_data_d[o] = in_data[WIDTH_packet +: WIDTH_packet];
                    3'b100:  slot_data_d[o] = in_data[2*WIDTH_packet +: WIDTH_packet];
                    default: slot_data_d[o] = in_data[0 +: WIDTH_packet];
                endcase
            end else if ((slot_state[o] == SLOT_FULL) && out_ready[o]) begin
                slot_state_d[o] = SLOT_EMPTY;
            end
        end
        drop_d = parent_misroute;
    end

    // State registers; reset discards any held packet immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < 3; o++) begin
                slot_state[o] <= SLOT_EMPTY;
                slot_data[o]  <= '0;
                rr_ptr[o]     <= 2'd0;
            end
            drop_q <= 1'b0;
        end else begin
            for (int o = 0; o < 3; o++) begin
                slot_state[o] <= slot_state_d[o];
                slot_data[o]  <= slot_data_d[o];
                rr_ptr[o]     <= rr_ptr_d[o];
            end
            drop_q <= drop_d;
        end
    end

    // Registered outputs straight from the slots.
    for (genvar go = 0; go < 3; go++) begin : g_out
        assign out_valid[go]                           = (slot_state[go] == SLOT_FULL);
        assign out_data[go*WIDTH_packet +: WIDTH_packet] = slot_data[go];
    end

    assign drop_err = drop_q;

endmodule
